// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared MIPS encoding constants: opcodes, functs, the loader
//               operation enumeration, field positions and word builders.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Default byte address of the first text word
    localparam logic [31:0] c_base_addr_default = 32'h0000_3000;

    // Operation selector presented by the loader front end
    typedef enum logic [3:0] {
        OP_ADDU   = 4'd0,
        OP_SUBU   = 4'd1,
        OP_AND    = 4'd2,
        OP_XOR    = 4'd3,
        OP_SLL    = 4'd4,
        OP_JR     = 4'd5,
        OP_JALR   = 4'd6,
        OP_ORI    = 4'd7,
        OP_ADDI   = 4'd8,
        OP_LUI    = 4'd9,
        OP_LW     = 4'd10,
        OP_SW     = 4'd11,
        OP_BEQ    = 4'd12,
        OP_J      = 4'd13,
        OP_JAL    = 4'd14,
        OP_BLTZAL = 4'd15
    } op_e;

    // Field LSB positions within the 32-bit word
    localparam int c_opcode_lsb = 26;
    localparam int c_rs_lsb     = 21;
    localparam int c_rt_lsb     = 16;
    localparam int c_rd_lsb     = 11;
    localparam int c_shamt_lsb  = 6;

    // Primary opcodes
    localparam logic [5:0] c_opc_rtype  = 6'h00;
    localparam logic [5:0] c_opc_regimm = 6'h01;
    localparam logic [5:0] c_opc_j      = 6'h02;
    localparam logic [5:0] c_opc_jal    = 6'h03;
    localparam logic [5:0] c_opc_beq    = 6'h04;
    localparam logic [5:0] c_opc_addi   = 6'h08;
    localparam logic [5:0] c_opc_ori    = 6'h0D;
    localparam logic [5:0] c_opc_lui    = 6'h0F;
    localparam logic [5:0] c_opc_lw     = 6'h23;
    localparam logic [5:0] c_opc_sw     = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_jalr = 6'h09;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_xor  = 6'h26;

    // REGIMM rt selector for BLTZAL
    localparam logic [4:0] c_rt_bltzal = 5'h10;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return (32'(c_opc_rtype) << c_opcode_lsb) | (32'(rs) << c_rs_lsb) |
               (32'(rt) << c_rt_lsb) | (32'(rd) << c_rd_lsb) |
               (32'(shamt) << c_shamt_lsb) | 32'(funct);
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opcode, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return (32'(opcode) << c_opcode_lsb) | (32'(rs) << c_rs_lsb) |
               (32'(rt) << c_rt_lsb) | 32'(imm);
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opcode, input logic [25:0] idx);
        return (32'(opcode) << c_opcode_lsb) | 32'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_branch_off_calc.sv
`default_nettype none
// ============================================================================
// Module      : branch_off_calc
// Description : Combinational PC-relative offset, range, alignment and
//               256 MB region checks for branch and jump targets.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_off_calc (
    input  logic [31:0] pc,
    input  logic [31:0] target,
    output logic [15:0] off,
    output logic        range_ok,
    output logic        align_ok,
    output logic        region_ok
);

    logic [31:0] w_pc4;
    logic [31:0] w_diff;
    logic [31:0] w_off32;

    // Word offset relative to the delay-slot PC, checked against signed 16 bits
    always_comb begin
        w_pc4     = pc + 32'd4;
        w_diff    = target - w_pc4;
        w_off32   = $signed(w_diff) >>> 2;
        range_ok  = (w_off32[31:15] == '0) || (w_off32[31:15] == '1);
        off       = w_off32[15:0];
        align_ok  = (target[1:0] == 2'b00);
        region_ok = (target[31:28] == w_pc4[31:28]);
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Sequential MIPS instruction encoder and instruction-memory
//               writer used as the program loader ahead of CPU release.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = c_base_addr_default,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        full,
    output logic        err
);

    localparam int                c_ptr_w    = $clog2(DEPTH_WORDS + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH_WORDS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_full = 2'd2;

    logic [1:0]         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic               r_wr_en;
    logic [31:0]        r_wr_addr;
    logic [31:0]        r_wr_data;
    logic               r_full;
    logic               r_err;

    logic [31:0] w_pc;
    logic        w_at_depth;
    logic        w_accept;
    logic [15:0] w_off;
    logic        w_range_ok;
    logic        w_align_ok;
    logic        w_region_ok;
    logic [31:0] w_word;
    logic        w_ok;

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign full    = r_full;
    assign err     = r_err;

    // Once the last slot is claimed no further bundle may be taken, even while
    // that final write is still waiting on the IM.
    always_comb begin
        w_pc       = BASE_ADDR + (32'(r_ptr) << 2);
        w_at_depth = (r_ptr == c_ptr_last);
        in_ready   = (r_state == c_st_run) && !w_at_depth && (!r_wr_en || wr_ready);
        w_accept   = in_valid && in_ready;
    end

    branch_off_calc u_branch_off_calc (
        .pc        (w_pc),
        .target    (in_target),
        .off       (w_off),
        .range_ok  (w_range_ok),
        .align_ok  (w_align_ok),
        .region_ok (w_region_ok)
    );

    // Assemble the machine word and decide whether the target is encodable
    always_comb begin
        w_word = '0;
        w_ok   = 1'b1;
        case (op_e'(in_op))
            OP_ADDU:   w_word = enc_r(in_rs, in_rt, in_rd, 5'd0, c_fn_addu);
            OP_SUBU:   w_word = enc_r(in_rs, in_rt, in_rd, 5'd0, c_fn_subu);
            OP_AND:    w_word = enc_r(in_rs, in_rt, in_rd, 5'd0, c_fn_and);
            OP_XOR:    w_word = enc_r(in_rs, in_rt, in_rd, 5'd0, c_fn_xor);
            OP_SLL:    w_word = enc_r(5'd0, in_rt, in_rd, in_shamt, c_fn_sll);
            OP_JR:     w_word = enc_r(in_rs, 5'd0, 5'd0, 5'd0, c_fn_jr);
            OP_JALR:   w_word = enc_r(in_rs, 5'd0, in_rd, 5'd0, c_fn_jalr);
            OP_ORI:    w_word = enc_i(c_opc_ori, in_rs, in_rt, in_imm);
            OP_ADDI:   w_word = enc_i(c_opc_addi, in_rs, in_rt, in_imm);
            OP_LUI:    w_word = enc_i(c_opc_lui, 5'd0, in_rt, in_imm);
            OP_LW:     w_word = enc_i(c_opc_lw, in_rs, in_rt, in_imm);
            OP_SW:     w_word = enc_i(c_opc_sw, in_rs, in_rt, in_imm);
            OP_BEQ: begin
                w_word = enc_i(c_opc_beq, in_rs, in_rt, w_off);
                w_ok   = w_align_ok && w_range_ok;
            end
            OP_BLTZAL: begin
                w_word = enc_i(c_opc_regimm, in_rs, c_rt_bltzal, w_off);
                w_ok   = w_align_ok && w_range_ok;
            end
            OP_J: begin
                w_word = enc_j(c_opc_j, in_target[27:2]);
                w_ok   = w_align_ok && w_region_ok;
            end
            OP_JAL: begin
                w_word = enc_j(c_opc_jal, in_target[27:2]);
                w_ok   = w_align_ok && w_region_ok;
            end
            default: begin
                w_word = '0;
                w_ok   = 1'b1;
            end
        endcase
    end

    // Loader FSM, write pointer and registered IM write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_full    <= 1'b0;
            r_err     <= 1'b0;
        end else if (start) begin
            r_state <= c_st_run;
            r_ptr   <= '0;
            r_wr_en <= 1'b0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (r_wr_en && wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (w_at_depth) begin
                            r_state <= c_st_full;
                            r_full  <= 1'b1;
                        end
                    end
                    if (w_accept) begin
                        if (w_ok) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_pc;
                            r_wr_data <= w_word;
                            r_ptr     <= r_ptr + 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_full: r_state <= c_st_full;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed, table-driven bench for instr_encoder (4-word IM).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] tgt;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, wr_en, wr_ready, full, err;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [31:0] in_target, wr_addr, wr_data;

    int checks = 0;
    int errors = 0;
    vec_t vt[16];
    vec_t v;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0000_3000), .DEPTH_WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .full(full), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                                input logic [31:0] tgt, input logic [31:0] exp);
        vec_t r;
        r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh; r.imm = imm; r.tgt = tgt; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t d);
        in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_shamt = d.sh;
        in_imm = d.imm; in_target = d.tgt; in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offer a bundle, wait (bounded) for the handshake, return at the negedge after accept
    task automatic offer(input vec_t d);
        int n;
        @(negedge clk);
        drive(d);
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // Directed vectors, four per start (IM depth 4); addr = 0x3000 + 4*(i%4)
        vt[0]  = mk(OP_ADDU,   5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    32'h0,    32'h0022_1821);
        vt[1]  = mk(OP_SUBU,   5'd4,  5'd5,  5'd6,  5'd0,  16'h0,    32'h0,    32'h0085_3023);
        vt[2]  = mk(OP_AND,    5'd7,  5'd8,  5'd9,  5'd0,  16'h0,    32'h0,    32'h00E8_4824);
        vt[3]  = mk(OP_XOR,    5'd10, 5'd11, 5'd12, 5'd0,  16'h0,    32'h0,    32'h014B_6026);
        vt[4]  = mk(OP_SLL,    5'd31, 5'd3,  5'd4,  5'd5,  16'h0,    32'h0,    32'h0003_2140);
        vt[5]  = mk(OP_JR,     5'd31, 5'd7,  5'd7,  5'd3,  16'h0,    32'h0,    32'h03E0_0008);
        vt[6]  = mk(OP_JALR,   5'd2,  5'd9,  5'd31, 5'd0,  16'h0,    32'h0,    32'h0040_F809);
        vt[7]  = mk(OP_ADDI,   5'd1,  5'd2,  5'd5,  5'd0,  16'hFFFF, 32'h0,    32'h2022_FFFF);
        vt[8]  = mk(OP_LW,     5'd29, 5'd8,  5'd0,  5'd0,  16'h0010, 32'h0,    32'h8FA8_0010);
        vt[9]  = mk(OP_SW,     5'd29, 5'd9,  5'd0,  5'd0,  16'h0014, 32'h0,    32'hAFA9_0014);
        vt[10] = mk(OP_JAL,    5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    32'h3000, 32'h0C00_0C00);
        vt[11] = mk(OP_BLTZAL, 5'd3,  5'd0,  5'd0,  5'd0,  16'h0,    32'h3020, 32'h0470_0004);
        vt[12] = mk(OP_ORI,    5'd0,  5'd1,  5'd0,  5'd0,  16'h1234, 32'h0,    32'h3401_1234);
        vt[13] = mk(OP_LUI,    5'd7,  5'd5,  5'd0,  5'd0,  16'hABCD, 32'h0,    32'h3C05_ABCD);
        vt[14] = mk(OP_BEQ,    5'd1,  5'd2,  5'd0,  5'd0,  16'h0,    32'h3000, 32'h1022_FFFD);
        vt[15] = mk(OP_J,      5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    32'h3010, 32'h0800_0C04);

        reset = 1'b0; start = 1'b0; wr_ready = 1'b1;
        drive(vt[0]); in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        in_valid = 1'b1;
        @(negedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Table-driven encodings
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) pulse_start();
            offer(vt[i]);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'd1);
            chk($sformatf("v%0d_addr", i), wr_addr, 32'h3000 + 32'(4 * (i % 4)));
            chk($sformatf("v%0d_data", i), wr_data, vt[i].exp);
            chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
        end

        // Out-of-range branch: consumed, flagged, nothing written, pointer held
        pulse_start();
        chk("start_clears_err", 32'(err), 32'd0);
        offer(mk(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0002_3004, 32'h0));
        chk("badbeq_err", 32'(err), 32'd1);
        chk("badbeq_wr_en", 32'(wr_en), 32'd0);
        offer(vt[0]);
        chk("after_err_addr", wr_addr, 32'h3000);
        chk("after_err_data", wr_data, 32'h0022_1821);
        chk("err_sticky", 32'(err), 32'd1);
        offer(mk(OP_BEQ, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'hFFFE_3008, 32'h0));
        chk("beq_min_addr", wr_addr, 32'h3004);
        chk("beq_min_data", wr_data, 32'h1000_8000);
        offer(mk(OP_BEQ, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0002_3008, 32'h0));
        chk("beq_max_addr", wr_addr, 32'h3008);
        chk("beq_max_data", wr_data, 32'h1000_7FFF);

        // Jump alignment and region errors
        pulse_start();
        offer(mk(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_3002, 32'h0));
        chk("j_misalign_err", 32'(err), 32'd1);
        chk("j_misalign_wr_en", 32'(wr_en), 32'd0);
        pulse_start();
        offer(mk(OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 32'h0));
        chk("jal_region_err", 32'(err), 32'd1);
        chk("jal_region_wr_en", 32'(wr_en), 32'd0);

        // Back-pressure: word held, no new accept, nothing lost
        pulse_start();
        wr_ready = 1'b0;
        offer(vt[0]);
        drive(vt[12]);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_wr_en", k), 32'(wr_en), 32'd1);
            chk($sformatf("stall%0d_addr", k), wr_addr, 32'h3000);
            chk($sformatf("stall%0d_data", k), wr_data, 32'h0022_1821);
            @(negedge clk);
        end
        wr_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("unstall_wr_en", 32'(wr_en), 32'd1);
        chk("unstall_addr", wr_addr, 32'h3004);
        chk("unstall_data", wr_data, 32'h3401_1234);
        @(negedge clk);
        chk("drain_wr_en", 32'(wr_en), 32'd0);

        // Reset while a write is pending
        wr_ready = 1'b0;
        pulse_start();
        offer(vt[1]);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", wr_addr, 32'd0);
        reset = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);

        // Fill the 4-word IM, fifth bundle refused, restart
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            offer(vt[k]);
            chk($sformatf("fill%0d_addr", k), wr_addr, 32'h3000 + 32'(4 * k));
        end
        chk("fill_not_full_yet", 32'(full), 32'd0);
        drive(vt[4]);
        #1;
        chk("fill_last_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_wr_en", 32'(wr_en), 32'd0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        chk("full_hold_wr_en", 32'(wr_en), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        chk("restart_full", 32'(full), 32'd0);
        offer(vt[5]);
        chk("restart_addr", wr_addr, 32'h3000);
        chk("restart_data", wr_data, 32'h03E0_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit in case a wait stalls
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory writer. It accepts decoded instruction fields over a valid/ready handshake, assembles the 32-bit machine word for the supported subset, and writes it to consecutive instruction-memory words starting at the text base. It computes branch and jump fields from absolute targets. It runs beside the IM as the program loader used before the CPU is released from reset.

## Interface
- BASE_ADDR, 32'h0000_3000: byte address of the first word written.
- DEPTH_WORDS, 1024: IM capacity in words; must be at least 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; clears the write pointer and `err` and enters RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_op  in  4  0 ADDU, 1 SUBU, 2 AND, 3 XOR, 4 SLL, 5 JR, 6 JALR, 7 ORI, 8 ADDI, 9 LUI, 10 LW, 11 SW, 12 BEQ, 13 J, 14 JAL, 15 BLTZAL.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate for ORI/ADDI/LUI/LW/SW.
- in_target  in  32  absolute byte target for BEQ/BLTZAL/J/JAL.
- wr_en  out  1  IM write request; held until accepted.
- wr_ready  in  1  IM accepts the write.
- wr_addr  out  32  byte address of the word.
- wr_data  out  32  encoded word.
- full  out  1  DEPTH_WORDS words written.
- err  out  1  sticky encoding error.

## Operation
- FSM states: IDLE, RUN, FULL. Reset puts the block in IDLE.
- Reset values: state IDLE, ptr 0, wr_en 0, wr_addr 0, wr_data 0, full 0, err 0, in_ready 0.
- IDLE: in_ready 0. `start` moves to RUN with ptr 0.
- RUN: in_ready = !wr_en || wr_ready.
  - On accept (in_valid && in_ready): pc = BASE_ADDR + 4·ptr. The word is encoded and loaded into the output register, wr_en is set, and ptr increments.
- FULL is entered when the write that makes ptr == DEPTH_WORDS is accepted by the IM. In FULL: full 1, in_ready 0. `start` returns to RUN with ptr 0 and clears full and err.
- `start` in any state overrides the accept in the same cycle and drops any pending wr_en.
- R-type encodings (opcode 0):
  - ADDU funct 0x21, SUBU 0x23, AND 0x24, XOR 0x26: fields rs/rt/rd.
  - SLL funct 0x00: rt/rd/shamt, rs forced to 0.
  - JR funct 0x08: rs only.
  - JALR funct 0x09: rs and rd.
  - All unused fields forced to 0.
- I-type opcodes: ORI 0x0D, ADDI 0x08, LUI 0x0F (rs forced 0), LW 0x23, SW 0x2B.
- BEQ (opcode 0x04):
  - off = (in_target − (pc+4)) >>> 2, arithmetic, computed at 32 bits.
  - Valid only if in_target[1:0] == 0 and off lies in [−32768, 32767]; the word carries off[15:0].
- BLTZAL: opcode 0x01, rt field = 0x10, offset computed as for BEQ.
- J 0x02 / JAL 0x03:
  - in_target[31:28] must equal (pc+4)[31:28] and in_target[1:0] must be 0.
  - Field = in_target[27:2].
- Error rule: an invalid branch or jump sets err and is not written. The bundle is still consumed (in_ready handshake completes), ptr does not advance, and wr_en is not set.

## Timing
- Latency: 1 cycle from accept to wr_en/wr_addr/wr_data valid.
- wr_addr/wr_data are stable while wr_en=1 && !wr_ready.
- Throughput is 1 word/cycle when wr_ready is held high. Back-to-back accepts with wr_ready=0 stall after the first.
- in_ready depends combinationally on wr_ready. No other input-to-output combinational path exists.
- Reset asserted mid-write drops wr_en the next cycle; no partial state is retained.

## Structure
- Shared package: opcode/funct constants, the in_op enumeration, BASE_ADDR default, and the R/I/J field position constants. The CPU controller's decode table uses the same constants.
- Sub-module: `branch_off_calc` (combinational). It takes pc and target and produces off[15:0], range_ok and align_ok, and is reused for the J-field region check.
- Top level holds the FSM, the pointer, and the output register.

## Test plan
- start, ADDU rs=1 rt=2 rd=3 with wr_ready=1 -> wr_en next cycle, wr_addr 0x3000, wr_data 0x00221821.
- ORI rt=1 imm=0x1234, then LUI rt=5 imm=0xABCD -> 0x34011234 @0x3000, 0x3C05ABCD @0x3004.
- Two fillers, then BEQ rs=1 rt=2 target 0x3000 at pc 0x3008 -> 0x1022FFFD. J target 0x3010 at pc 0x300C -> 0x08000C04.
- BEQ at pc 0x3000 with target 0x23004 (off 0x8000) -> err=1, no wr_en, ptr unchanged. The next valid op writes at 0x3000.
- wr_ready=0 for 3 cycles with in_valid continuously high -> wr_en/data held constant, in_ready 0 until wr_ready, no word lost.
- DEPTH_WORDS=4: five bundles -> four writes, full=1 after the fourth is accepted, fifth not accepted. start -> full=0, the next write goes to 0x3000.
